driver_fire_scheduler: RTL
==========================

# driver_fire_scheduler

Command-driven sequencer that owns every control input of one `driver_core` and runs in that core's `clock_a` domain. It performs two jobs:
- Firing-memory writes, with address, data and write strobe held long enough to cross the core's synchronizers.
- Row or column refresh sweeps: per index, a normal pulse and then an inverted reset pulse, with programmable pulse and dead time.

A host issues commands over a valid/ready handshake. The scheduler guarantees that `output_active` is never high while selects or inversion are changing.

## Interface
Parameters:
- MEM_LENGTH, 48, driver memory depth (passed through for consistency with `driver_core`)
- MEM_ADDRESS_LENGTH, 6, select width; memory address is 2*MEM_ADDRESS_LENGTH bits
- HOLD_CYCLES, 4, minimum cycles any field is stable around a strobe or pulse edge; must be at least 1
- CNT_WIDTH, 16, width of the pulse and dead-time counters

Ports:
- clock  in  1  single clock (feeds `driver_core` `clock_a`)
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle where valid && ready
- cmd_op  in  1  0 = memory write, 1 = sweep
- cmd_addr  in  2*MEM_ADDRESS_LENGTH  write address
- cmd_data  in  16  write data
- cfg_pulse_len  in  CNT_WIDTH  fire cycles; latched at sweep accept; 0 is treated as 1
- cfg_dead_len  in  CNT_WIDTH  off cycles after each pulse; latched at sweep accept; 0 skips the dead phase
- cfg_last_row  in  MEM_ADDRESS_LENGTH  last sweep index, inclusive; latched at accept
- cfg_row_col  in  1  sweep axis, 0 = rows, 1 = columns; latched at accept
- abort  in  1  terminate the sweep in progress
- busy  out  1  high whenever not IDLE
- sweep_done  out  1  one-cycle pulse when a sweep completes normally
- mem_address, mem_write_n, row_select, col_select, data_in, row_col_select, output_active, inverter_select  out  widths match the `driver_core` `_a` inputs; all registered

## Operation
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, SW_SETUP, SW_FIRE, SW_DEAD, DRAIN.

Write command:
- Sequence is WR_SETUP → WR_STROBE → WR_HOLD, each HOLD_CYCLES long, then IDLE.
- `mem_address` and `data_in` are loaded at accept and held through WR_HOLD.
- `mem_write_n` is 0 only in WR_STROBE.

Sweep command:
- Index i runs from 0 to last_row. Phase p = 0, then p = 1.
- Per phase: SW_SETUP (HOLD_CYCLES cycles) → SW_FIRE (pulse_len cycles) → SW_DEAD (dead_len cycles).
- After p = 1, the index increments. After the last index, the block returns to IDLE and pulses `sweep_done`.
- `row_col_select` equals the latched axis for the whole sweep.
- The selected axis output (`row_select` for rows, `col_select` for columns) equals i; the other select is held at 0.
- `inverter_select` equals p.
- `output_active` is 1 only in SW_FIRE.
- Select and inversion outputs change only on entry to SW_SETUP.

Abort:
- Honoured in SW_SETUP, SW_FIRE and SW_DEAD.
- `output_active` goes 0 on the next edge; state moves to DRAIN for HOLD_CYCLES cycles, then IDLE.
- No `sweep_done` is issued. Abort is ignored in IDLE and in the write states.

- Config inputs are sampled only at sweep accept; changes mid-sweep have no effect.
- Writes are never accepted during a sweep, because `cmd_ready` is low.

## Timing
- Reset values: `cmd_ready` 0, `mem_write_n` 1, every other output 0, state IDLE, counters 0.
- `cmd_ready` rises on the first edge after `reset_n` is released.
- Reset asserted mid-operation forces these reset values on the next edge. `output_active` therefore drops within 1 cycle.
- `busy` rises on the edge that accepts a command.
- Write latency: 3*HOLD_CYCLES cycles from accept to `cmd_ready` high again.
- Sweep duration: (last_row+1) * 2 * (HOLD_CYCLES + max(pulse_len,1) + dead_len) cycles from accept.
  - `sweep_done` and `cmd_ready` rise on the same edge that ends the last dead phase.
- With `cfg_last_row` at its maximum (2^MEM_ADDRESS_LENGTH − 1), the index must not wrap. Termination compares against last_row before incrementing.
- Counters load the phase length minus 1 and count down to 0. They must not overflow at `cfg_pulse_len` = 2^CNT_WIDTH − 1.
- `abort` sampled on the same edge as the final SW_DEAD cycle of the last index: abort wins, so DRAIN is entered and `sweep_done` is 0.
- A new command may be accepted the cycle after IDLE is re-entered.

## Test plan
- Reset, then write addr=0x02A data=0xBEEF with HOLD=4:
  - `mem_write_n` low for exactly cycles 5–8 after accept.
  - Address and data are stable during cycles 1–12.
  - `cmd_ready` returns at cycle 12.
- Row sweep with last_row=2, pulse=3, dead=2, HOLD=4:
  - 54 busy cycles.
  - Six `output_active` pulses of 3 cycles each, `inverter_select` pattern 0,1 per row.
  - `row_select` 0,1,2, `col_select` 0.
  - One `sweep_done` pulse.
- Column sweep with pulse=0, dead=0, last_row=0:
  - Two 1-cycle fire pulses, no dead cycles.
  - `row_col_select`=1, `col_select`=0.
  - Total duration 10 cycles.
- `abort` asserted in the second SW_FIRE cycle of row 1:
  - `output_active` is 0 next cycle.
  - DRAIN lasts 4 cycles, then IDLE.
  - No `sweep_done`.
- Assert `reset_n`=0 mid-fire, and separately offer `cmd_valid` during a sweep:
  - Reset: all outputs take reset values in 1 cycle.
  - Mid-sweep command: not accepted until `cmd_ready` returns high.
- last_row=63 sweep with pulse=1, dead=0:
  - 128 pulses, index stops at 63 without wrapping.
  - `sweep_done` exactly once.

Source files
------------

// File: rtl/driver_fire_scheduler.sv
// driver_fire_scheduler
//
// Command-driven sequencer that owns every control input of one driver_core.
// It runs in that core's clock_a domain and performs two jobs:
//   * memory write: WR_SETUP -> WR_STROBE -> WR_HOLD, each HOLD_CYCLES long, so
//     the address, data and strobe cross the core's synchronizers cleanly.
//   * refresh sweep: for every index 0..last_row, a normal phase (p=0) and then
//     an inverted phase (p=1). Each phase is SW_SETUP (HOLD_CYCLES),
//     SW_FIRE (pulse_len, 0 counts as 1) and SW_DEAD (dead_len, 0 skips it).
// Selects and inversion change only on entry to SW_SETUP, so output_active is
// never high while they move. An abort during a sweep drains for HOLD_CYCLES.
//
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready is high only in IDLE
//   cmd_op                0 = memory write, 1 = sweep
//   cmd_addr, cmd_data    write address / data, loaded at accept
//   cfg_*                 sweep configuration, latched at sweep accept
//   abort                 terminate a running sweep
//   busy, sweep_done      status; sweep_done is a 1-cycle pulse
//   mem_address .. inverter_select   registered driver_core _a controls
module driver_fire_scheduler #(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int HOLD_CYCLES        = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [2*MEM_ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [15:0]                     cmd_data,
  input  logic [CNT_WIDTH-1:0]            cfg_pulse_len,
  input  logic [CNT_WIDTH-1:0]            cfg_dead_len,
  input  logic [MEM_ADDRESS_LENGTH-1:0]   cfg_last_row,
  input  logic                            cfg_row_col,
  input  logic                            abort,
  output logic                            busy,
  output logic                            sweep_done,
  output logic [2*MEM_ADDRESS_LENGTH-1:0] mem_address,
  output logic                            mem_write_n,
  output logic [MEM_ADDRESS_LENGTH-1:0]   row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0]   col_select,
  output logic [15:0]                     data_in,
  output logic                            row_col_select,
  output logic                            output_active,
  output logic                            inverter_select
);

  localparam int AW = MEM_ADDRESS_LENGTH;
  localparam logic [CNT_WIDTH-1:0] HOLD_M1 = CNT_WIDTH'(HOLD_CYCLES - 1);

  // Reject parameter sets the sequencing cannot honour.
  if (HOLD_CYCLES < 1 || MEM_LENGTH < 1 || MEM_LENGTH > (1 << (2 * MEM_ADDRESS_LENGTH))) begin : g_bad_params
    $error("driver_fire_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_STROBE = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_SW_SETUP  = 3'd4,
    ST_SW_FIRE   = 3'd5,
    ST_SW_DEAD   = 3'd6,
    ST_DRAIN     = 3'd7
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
  logic [AW-1:0]         idx_r, idx_s;
  logic                  phase_r, phase_s;
  logic                  axis_r, axis_s;
  logic [AW-1:0]         last_r, last_s;
  logic [CNT_WIDTH-1:0]  pulse_m1_r, pulse_m1_s;
  logic [CNT_WIDTH-1:0]  dead_r, dead_s;
  logic [2*AW-1:0]       addr_r, addr_s;
  logic [15:0]           data_r, data_s;
  logic                  done_s;
  logic                  phase_end_s;

  logic                  cmd_ready_r, busy_r, done_r, wr_n_r, act_r, inv_r, rcs_r;
  logic [AW-1:0]         row_r, col_r;

  assign cmd_ready       = cmd_ready_r;
  assign busy            = busy_r;
  assign sweep_done      = done_r;
  assign mem_address     = addr_r;
  assign data_in         = data_r;
  assign mem_write_n     = wr_n_r;
  assign output_active   = act_r;
  assign row_select      = row_r;
  assign col_select      = col_r;
  assign inverter_select = inv_r;
  assign row_col_select  = rcs_r;

  // Next-state, counter and sweep-bookkeeping logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    phase_s     = phase_r;
    axis_s      = axis_r;
    last_s      = last_r;
    pulse_m1_s  = pulse_m1_r;
    dead_s      = dead_r;
    addr_s      = addr_r;
    data_s      = data_r;
    done_s      = 1'b0;
    phase_end_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // cmd_ready_r is low on the first cycle after reset, so gate on it.
        if (cmd_valid && cmd_ready_r) begin
          cnt_s = HOLD_M1;
          if (cmd_op) begin
            state_s    = ST_SW_SETUP;
            idx_s      = '0;
            phase_s    = 1'b0;
            axis_s     = cfg_row_col;
            last_s     = cfg_last_row;
            // A zero pulse length behaves as one cycle.
            pulse_m1_s = (cfg_pulse_len == '0) ? '0 : cfg_pulse_len - CNT_WIDTH'(1);
            dead_s     = cfg_dead_len;
          end else begin
            state_s = ST_WR_SETUP;
            addr_s  = cmd_addr;
            data_s  = cmd_data;
          end
        end else begin
          cnt_s = '0;
        end
      end
      ST_WR_SETUP: begin
        if (cnt_r == '0) begin
          state_s = ST_WR_STROBE;
          cnt_s   = HOLD_M1;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_WR_STROBE: begin
        if (cnt_r == '0) begin
          state_s = ST_WR_HOLD;
          cnt_s   = HOLD_M1;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_WR_HOLD: begin
        if (cnt_r == '0) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_SW_SETUP: begin
        if (abort) begin
          state_s = ST_DRAIN;
          cnt_s   = HOLD_M1;
        end else if (cnt_r == '0) begin
          state_s = ST_SW_FIRE;
          cnt_s   = pulse_m1_r;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_SW_FIRE: begin
        if (abort) begin
          state_s = ST_DRAIN;
          cnt_s   = HOLD_M1;
        end else if (cnt_r == '0) begin
          if (dead_r != '0) begin
            state_s = ST_SW_DEAD;
            cnt_s   = dead_r - CNT_WIDTH'(1);
          end else begin
            phase_end_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_SW_DEAD: begin
        // Abort has priority even on the very last dead cycle.
        if (abort) begin
          state_s = ST_DRAIN;
          cnt_s   = HOLD_M1;
        end else if (cnt_r == '0) begin
          phase_end_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_r == '0) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase

    // End of a phase: inverted phase next, then next index or finish.
    // The last-index test happens before incrementing so a full-range
    // last_row never wraps.
    if (phase_end_s) begin
      if (!phase_r) begin
        state_s = ST_SW_SETUP;
        cnt_s   = HOLD_M1;
        phase_s = 1'b1;
      end else if (idx_r == last_r) begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        done_s  = 1'b1;
      end else begin
        state_s = ST_SW_SETUP;
        cnt_s   = HOLD_M1;
        idx_s   = idx_r + AW'(1);
        phase_s = 1'b0;
      end
    end else begin
      done_s = 1'b0;
    end
  end

  // State, bookkeeping and registered outputs, all decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      phase_r     <= 1'b0;
      axis_r      <= 1'b0;
      last_r      <= '0;
      pulse_m1_r  <= '0;
      dead_r      <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_n_r      <= 1'b1;
      act_r       <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      inv_r       <= 1'b0;
      rcs_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      phase_r     <= phase_s;
      axis_r      <= axis_s;
      last_r      <= last_s;
      pulse_m1_r  <= pulse_m1_s;
      dead_r      <= dead_s;
      addr_r      <= addr_s;
      data_r      <= data_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= done_s;
      wr_n_r      <= (state_s != ST_WR_STROBE);
      act_r       <= (state_s == ST_SW_FIRE);
      // idx/phase/axis only move on entry to SW_SETUP, so these do too.
      row_r       <= axis_s ? '0 : idx_s;
      col_r       <= axis_s ? idx_s : '0;
      inv_r       <= phase_s;
      rcs_r       <= axis_s;
    end
  end

endmodule
